// File: rtl/ped_signal_if.sv
// Pedestrian stage port bundle: car-state/button inputs and pedestrian lamp outputs.
interface ped_signal_if;
  logic       btn_raw;
  logic [2:0] cur_state;
  logic       ped_red;
  logic       ped_green;
  logic       wait_led;
  logic [1:0] ped_state;

  modport master (
    output btn_raw, cur_state,
    input  ped_red, ped_green, wait_led, ped_state
  );

  modport slave (
    input  btn_raw, cur_state,
    output ped_red, ped_green, wait_led, ped_state
  );
endinterface

// File: rtl/ped_signal.sv
// Pedestrian crossing stage: debounces the push-button, latches a request and
// grants walk + blinking clearance at the start of each car-red phase.
module ped_signal #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WALK_CYCLES     = 5,
  parameter int unsigned CLEAR_CYCLES    = 4
) (
  input  logic         clk,
  input  logic         resetn,
  ped_signal_if.slave  bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned CS_W  = 3;
  localparam logic [CS_W-1:0]  CS_RED    = CS_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {
    P_DARK  = 2'd0,
    P_STOP  = 2'd1,
    P_WALK  = 2'd2,
    P_CLEAR = 2'd3
  } ped_state_e;

  logic             s1, s2, db, db_q;
  logic [CNT_W-1:0] deb_cnt;
  logic [CS_W-1:0]  prev_state;

  ped_state_e       state, state_nxt;
  logic [CNT_W-1:0] phase_cnt, phase_cnt_nxt;
  logic             blink, blink_nxt;
  logic             req_pending, req_nxt;

  logic press, red_entry, grant, car_dark;

  // Button synchroniser, debounce counter and car-state history
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      db         <= 1'b0;
      db_q       <= 1'b0;
      deb_cnt    <= '0;
      prev_state <= '0;
    end else begin
      s1         <= bus.btn_raw;
      s2         <= s1;
      db_q       <= db;
      prev_state <= bus.cur_state;
      if (s2 == db) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        db      <= s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

  assign press     = db & ~db_q;
  assign red_entry = (bus.cur_state == CS_RED) && (prev_state != CS_RED);
  assign grant     = (state == P_STOP) && red_entry && (req_pending || press);
  assign car_dark  = bus.cur_state inside {3'd0, 3'd6, 3'd7};

  // Pedestrian FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= P_DARK;
      phase_cnt   <= '0;
      blink       <= 1'b0;
      req_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      phase_cnt   <= phase_cnt_nxt;
      blink       <= blink_nxt;
      req_pending <= req_nxt;
    end
  end

  // Next-state, phase timing and request latch
  always_comb begin
    state_nxt     = state;
    phase_cnt_nxt = phase_cnt;
    blink_nxt     = blink;
    req_nxt       = req_pending;

    if (grant) begin
      req_nxt = 1'b0;
    end else if (press && (state == P_DARK || state == P_STOP)) begin
      req_nxt = 1'b1;
    end

    if (car_dark) begin
      state_nxt = P_DARK;
    end else begin
      unique case (state)
        P_DARK: state_nxt = P_STOP;
        P_STOP: begin
          if (grant) begin
            state_nxt     = P_WALK;
            phase_cnt_nxt = '0;
          end
        end
        P_WALK: begin
          if (bus.cur_state != CS_RED) begin
            state_nxt = P_STOP;
          end else if (phase_cnt == WALK_LAST) begin
            state_nxt     = P_CLEAR;
            phase_cnt_nxt = '0;
            blink_nxt     = 1'b1;
          end else begin
            phase_cnt_nxt = phase_cnt + CNT_W'(1);
          end
        end
        P_CLEAR: begin
          if (bus.cur_state != CS_RED || phase_cnt == CLR_LAST) begin
            state_nxt = P_STOP;
          end else begin
            phase_cnt_nxt = phase_cnt + CNT_W'(1);
            blink_nxt     = ~blink;
          end
        end
        default: state_nxt = P_DARK;
      endcase
    end
  end

  // Lamp decode from registered state only
  assign bus.ped_red   = (state == P_STOP);
  assign bus.ped_green = (state == P_WALK) || ((state == P_CLEAR) && blink);
  assign bus.wait_led  = req_pending;
  assign bus.ped_state = state;

endmodule

// File: tb/tb_ped_signal.sv
// Cycle-by-cycle vector bench for ped_signal: each record holds the inputs for one
// clock edge and the lamp/state values expected after that edge.
module tb_ped_signal;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  ped_signal_if bus ();

  ped_signal dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic       rn;
    logic       btn;
    logic [2:0] cs;
    logic       red;
    logic       grn;
    logic       wt;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input logic rn, input logic btn, input logic [2:0] cs,
                     input logic red, input logic grn, input logic wt,
                     input logic [1:0] st, input int n);
    vec_t v;
    v.rn = rn; v.btn = btn; v.cs = cs;
    v.red = red; v.grn = grn; v.wt = wt; v.st = st;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Full walk sequence from the red_entry record: 5 steady green, 1,0,1,0 clearance, then stop
  task automatic add_walk(input logic btn);
    add(1, btn, 3'd1, 0, 1, 0, 2'd2, 5);
    add(1, btn, 3'd1, 0, 1, 0, 2'd3, 1);
    add(1, btn, 3'd1, 0, 0, 0, 2'd3, 1);
    add(1, btn, 3'd1, 0, 1, 0, 2'd3, 1);
    add(1, btn, 3'd1, 0, 0, 0, 2'd3, 1);
    add(1, btn, 3'd1, 1, 0, 0, 2'd1, 1);
  endtask

  // Debounced request from idle: wait_led rises on the 7th edge of a held press
  task automatic add_request;
    add(1, 1, 3'd3, 1, 0, 0, 2'd1, 6);
    add(1, 1, 3'd3, 1, 0, 1, 2'd1, 1);
  endtask

  initial begin
    vec_t e;
    logic [4:0] got, want;

    // Reset and idle
    add(0, 0, 3'd0, 0, 0, 0, 2'd0, 2);
    add(1, 0, 3'd3, 1, 0, 0, 2'd1, 3);
    // 3-cycle glitch must not register
    add(1, 1, 3'd3, 1, 0, 0, 2'd1, 3);
    add(1, 0, 3'd3, 1, 0, 0, 2'd1, 6);
    // Held press, then normal grant at red entry
    add_request();
    add(1, 1, 3'd5, 1, 0, 1, 2'd1, 1);
    add_walk(1);
    add(1, 1, 3'd1, 1, 0, 0, 2'd1, 1);
    add(1, 0, 3'd3, 1, 0, 0, 2'd1, 8);
    // Car cycle with no request, plus an invalid car state
    add(1, 0, 3'd5, 1, 0, 0, 2'd1, 2);
    add(1, 0, 3'd1, 1, 0, 0, 2'd1, 4);
    add(1, 0, 3'd2, 1, 0, 0, 2'd1, 1);
    add(1, 0, 3'd3, 1, 0, 0, 2'd1, 1);
    add(1, 0, 3'd7, 0, 0, 0, 2'd0, 1);
    add(1, 0, 3'd3, 1, 0, 0, 2'd1, 2);
    // Press pulse lands exactly on the red_entry cycle: granted, wait_led never rises
    add(1, 1, 3'd3, 1, 0, 0, 2'd1, 5);
    add(1, 1, 3'd5, 1, 0, 0, 2'd1, 1);
    add_walk(1);
    add(1, 0, 3'd2, 1, 0, 0, 2'd1, 1);
    add(1, 0, 3'd3, 1, 0, 0, 2'd1, 7);
    // Press two cycles into red waits for the next red; re-press during walk ignored
    add(1, 1, 3'd3, 1, 0, 0, 2'd1, 3);
    add(1, 1, 3'd5, 1, 0, 0, 2'd1, 1);
    add(1, 0, 3'd1, 1, 0, 0, 2'd1, 2);
    add(1, 0, 3'd1, 1, 0, 1, 2'd1, 2);
    add(1, 0, 3'd2, 1, 0, 1, 2'd1, 1);
    add(1, 0, 3'd3, 1, 0, 1, 2'd1, 1);
    add(1, 1, 3'd5, 1, 0, 1, 2'd1, 2);
    add_walk(1);
    add(1, 0, 3'd2, 1, 0, 0, 2'd1, 1);
    add(1, 0, 3'd3, 1, 0, 0, 2'd1, 7);
    // Safety abort: car leaves red during walk
    add_request();
    add(1, 1, 3'd5, 1, 0, 1, 2'd1, 1);
    add(1, 1, 3'd1, 0, 1, 0, 2'd2, 2);
    add(1, 1, 3'd2, 1, 0, 0, 2'd1, 1);
    add(1, 1, 3'd3, 1, 0, 0, 2'd1, 1);
    add(1, 0, 3'd3, 1, 0, 0, 2'd1, 8);
    // Car goes idle during clearance: lamps dark
    add_request();
    add(1, 1, 3'd5, 1, 0, 1, 2'd1, 1);
    add(1, 1, 3'd1, 0, 1, 0, 2'd2, 5);
    add(1, 1, 3'd1, 0, 1, 0, 2'd3, 1);
    add(1, 1, 3'd0, 0, 0, 0, 2'd0, 1);
    add(1, 1, 3'd3, 1, 0, 0, 2'd1, 1);
    add(1, 0, 3'd3, 1, 0, 0, 2'd1, 8);
    // Request survives dark, then reset in the middle of a walk
    add_request();
    add(1, 1, 3'd0, 0, 0, 1, 2'd0, 2);
    add(1, 1, 3'd5, 1, 0, 1, 2'd1, 1);
    add(1, 1, 3'd1, 0, 1, 0, 2'd2, 2);
    add(0, 0, 3'd1, 0, 0, 0, 2'd0, 1);
    add(1, 0, 3'd1, 1, 0, 0, 2'd1, 2);

    resetn        = 1'b0;
    bus.btn_raw   = 1'b0;
    bus.cur_state = 3'd0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      resetn        = vecs[i].rn;
      bus.btn_raw   = vecs[i].btn;
      bus.cur_state = vecs[i].cs;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e    = sb.pop_front();
      got  = {bus.ped_red, bus.ped_green, bus.wait_led, bus.ped_state};
      want = {e.red, e.grn, e.wt, e.st};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL step%0d {red,green,wait,state}: got %b expected %b", i, got, want);
      end
      n_cmp++;
      if (bus.ped_red === 1'b1 && bus.ped_green === 1'b1) begin
        n_bad++;
        $display("FAIL step%0d lamp_excl: red=%b green=%b, required not both 1",
                 i, bus.ped_red, bus.ped_green);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
